// File: rtl/bus_pkg.sv
// Shared types and constants for the snooping bus controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package bus_pkg;
  localparam int N_CPU     = 3;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 4;
  localparam int BUS_W     = 6;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_RMISS = 2'b01,
    OP_WMISS = 2'b10,
    OP_WB    = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SNOOP,
    MEM,
    RESP
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  function automatic logic [1:0] onehot_idx(logic [N_CPU-1:0] oh);
    return oh[1] ? 2'd1 : (oh[2] ? 2'd2 : 2'd0);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching from last_grant+1 mod N_CPU.
// Latency: combinational.
// Backpressure: none; losers simply keep requesting.
module rr_arbiter
  import bus_pkg::*;
(
  input  logic [N_CPU-1:0] req,
  input  logic [1:0]       last_grant,
  output logic [N_CPU-1:0] grant
);

  logic [1:0] idx;

  function automatic logic [1:0] next_cpu(logic [1:0] c);
    return (c >= 2'(N_CPU - 1)) ? 2'd0 : c + 2'd1;
  endfunction

  always_comb begin
    grant = '0;
    idx   = next_cpu(last_grant);
    for (int k = 0; k < N_CPU; k++) begin
      if (req[idx] && grant == '0) grant[idx] = 1'b1;
      idx = next_cpu(idx);
    end
  end

endmodule

// File: rtl/bus_controller.sv
// Snooping bus controller: arbitrates CPU misses/write-backs against an 8x4 memory.
// Latency: ack MEM_LAT+2 edges after accept for misses, MEM_LAT edges for write-backs.
// Backpressure: one transaction at a time; other CPUs hold req until acked.
module bus_controller
  import bus_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_CPU-1:0]        req,
  input  logic [2*N_CPU-1:0]      req_op,
  input  logic [ADDR_W*N_CPU-1:0] req_addr,
  input  logic [DATA_W*N_CPU-1:0] req_data,
  input  logic [N_CPU-1:0]        snoop_wb,
  input  logic [DATA_W*N_CPU-1:0] snoop_data,
  output logic [BUS_W-1:0]        bus_out,
  output logic [N_CPU-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);

  localparam logic [3:0] MEM_CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  txn_t              txn, new_txn;
  logic [N_CPU-1:0]  gnt, arb_grant, req_legal, flush_mask;
  logic [1:0]        last_grant;
  logic [3:0]        cnt;
  logic              flush_vld;
  logic [DATA_W-1:0] flush_dat;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_comb begin
    req_legal = '0;
    for (int i = 0; i < N_CPU; i++)
      req_legal[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
  end

  rr_arbiter u_arb (
    .req        (req_legal),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  always_comb begin
    new_txn = '0;
    for (int i = 0; i < N_CPU; i++)
      if (arb_grant[i])
        new_txn = '{op:   op_t'(req_op[2*i +: 2]),
                    addr: req_addr[ADDR_W*i +: ADDR_W],
                    data: req_data[DATA_W*i +: DATA_W]};
  end

  // Requester's own flush bit is masked; descending loop lets the lowest index win.
  always_comb begin
    flush_mask = snoop_wb & ~gnt;
    flush_dat  = '0;
    for (int i = N_CPU - 1; i >= 0; i--)
      if (flush_mask[i]) flush_dat = snoop_data[DATA_W*i +: DATA_W];
  end
  assign flush_vld = |flush_mask;

  always_comb begin
    state_nxt = state;
    bus_out   = '0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (|arb_grant) state_nxt = (new_txn.op == OP_WB) ? MEM : BCAST;
      BCAST: begin
        bus_out   = {1'b1, txn.op, txn.addr};
        state_nxt = SNOOP;
      end
      SNOOP: state_nxt = MEM;
      MEM:   if (cnt == '0) state_nxt = RESP;
      RESP: begin
        ack       = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      txn        <= '0;
      gnt        <= '0;
      last_grant <= 2'd2;
      cnt        <= '0;
      rdata      <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|arb_grant) begin
          txn <= new_txn;
          gnt <= arb_grant;
          cnt <= MEM_CNT_INIT;
        end
        SNOOP: begin
          cnt <= MEM_CNT_INIT;
          if (flush_vld) mem[txn.addr] <= flush_dat;
        end
        MEM: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (txn.op == OP_WB) begin
            mem[txn.addr] <= txn.data;
            rdata         <= '0;
          end else begin
            rdata <= mem[txn.addr];
          end
        end
        RESP: last_grant <= onehot_idx(gnt);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed table, corner sequences, random vs model.
module tb_bus_controller;
  localparam int MEM_LAT = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0;
  logic [5:0]  req_op = '0;
  logic [8:0]  req_addr = '0;
  logic [11:0] req_data = '0;
  logic [2:0]  snoop_wb = '0;
  logic [11:0] snoop_data = '0;
  logic [5:0]  bus_out;
  logic [2:0]  ack;
  logic [3:0]  rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mem_m [8];
  int         lg_m;

  typedef struct {
    int         cpu;
    logic [1:0] op;
    logic [2:0] addr;
    logic [3:0] data;
    logic [2:0] swb;
    logic [11:0] sdat;
    logic [2:0] eack;
    logic [3:0] erd;
    int         elat;
    logic [5:0] ebus;
  } vec_t;

  vec_t tbl [8];

  bus_controller #(.MEM_LAT(MEM_LAT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .snoop_wb   (snoop_wb),
    .snoop_data (snoop_data),
    .bus_out    (bus_out),
    .ack        (ack),
    .rdata      (rdata),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog timeout");
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = 4'h0;
    lg_m = 2;
  endtask

  task automatic do_reset(bit chk);
    reset_n = 1'b0;
    req = '0; req_op = '0; req_addr = '0; req_data = '0; snoop_wb = '0; snoop_data = '0;
    @(posedge clock); #1;
    if (chk) begin
      check("rst_bus_out", 32'(bus_out), 32'd0);
      check("rst_ack",     32'(ack),     32'd0);
      check("rst_rdata",   32'(rdata),   32'd0);
      check("rst_busy",    32'(busy),    32'd0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic int rr_pick(logic [2:0] legal, int lg);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (lg + k) % 3;
      if (legal[c]) return c;
    end
    return -1;
  endfunction

  // Transaction-level prediction from the current inputs; updates the memory model.
  task automatic predict(output int g, output logic [2:0] eack, output int lat,
                         output logic [3:0] erd, output logic [5:0] ebus);
    logic [2:0] legal, sm;
    logic [1:0] op;
    logic [2:0] a;
    int         fj;
    for (int i = 0; i < 3; i++) legal[i] = req[i] && (req_op[2*i +: 2] != 2'b00);
    g = rr_pick(legal, lg_m);
    eack = '0; lat = 0; erd = '0; ebus = '0;
    if (g < 0) return;
    op   = req_op[2*g +: 2];
    a    = req_addr[3*g +: 3];
    eack = 3'b001 << g;
    if (op == 2'b11) begin
      lat = MEM_LAT;
      mem_m[a] = req_data[4*g +: 4];
    end else begin
      lat  = MEM_LAT + 2;
      ebus = {1'b1, op, a};
      sm   = snoop_wb & ~eack;
      fj   = -1;
      for (int j = 0; j < 3; j++) if (sm[j] && fj < 0) fj = j;
      if (fj >= 0) mem_m[a] = snoop_data[4*fj +: 4];
      erd = mem_m[a];
    end
  endtask

  task automatic run_check(string nm, int g, logic [2:0] eack, int lat,
                           logic [3:0] erd, logic [5:0] ebus, bit scramble);
    int         e, nb;
    bit         busy_ok;
    logic [5:0] seen_bus;
    @(posedge clock); #1;
    if (scramble) begin
      req_op   = 6'($urandom);
      req_addr = 9'($urandom);
      req_data = 12'($urandom);
    end
    e = 0; nb = 0; busy_ok = 1'b1; seen_bus = '0;
    while (ack == 3'b000 && e < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (bus_out != 6'd0) begin nb++; seen_bus = bus_out; end
      @(posedge clock); #1;
      e++;
    end
    check({nm, "_latency"}, 32'(e), 32'(lat));
    check({nm, "_ack"},     32'(ack), 32'(eack));
    check({nm, "_rdata"},   32'(rdata), 32'(erd));
    check({nm, "_bcast_n"}, 32'(nb), (ebus != 6'd0) ? 32'd1 : 32'd0);
    check({nm, "_bus_out"}, 32'(seen_bus), 32'(ebus));
    check({nm, "_busy"},    32'(busy_ok), 32'd1);
    req[g] = 1'b0;
    lg_m = g;
    @(posedge clock); #1;
    check({nm, "_ack_1cyc"}, 32'(ack), 32'd0);
    check({nm, "_idle"},     32'(busy), 32'd0);
  endtask

  task automatic apply_vec(vec_t v);
    req        = 3'b001 << v.cpu;
    req_op     = 6'(v.op) << (2 * v.cpu);
    req_addr   = 9'(v.addr) << (3 * v.cpu);
    req_data   = 12'(v.data) << (4 * v.cpu);
    snoop_wb   = v.swb;
    snoop_data = v.sdat;
  endtask

  initial begin
    int         g, lat, ok;
    logic [2:0] eack;
    logic [3:0] erd;
    logic [5:0] ebus;
    logic [2:0] order [4];

    //            cpu op     addr  data  swb     sdat     eack    erd   lat        ebus
    tbl[0] = '{0, 2'b11, 3'd3, 4'hA, 3'b000, 12'h000, 3'b001, 4'h0, MEM_LAT,   6'b000000};
    tbl[1] = '{1, 2'b01, 3'd3, 4'h0, 3'b000, 12'h000, 3'b010, 4'hA, MEM_LAT+2, 6'b101011};
    tbl[2] = '{2, 2'b01, 3'd5, 4'h0, 3'b001, 12'h007, 3'b100, 4'h7, MEM_LAT+2, 6'b101101};
    tbl[3] = '{0, 2'b01, 3'd5, 4'h0, 3'b000, 12'h000, 3'b001, 4'h7, MEM_LAT+2, 6'b101101};
    tbl[4] = '{1, 2'b01, 3'd5, 4'h0, 3'b010, 12'h030, 3'b010, 4'h7, MEM_LAT+2, 6'b101101};
    tbl[5] = '{2, 2'b10, 3'd3, 4'h0, 3'b000, 12'h000, 3'b100, 4'hA, MEM_LAT+2, 6'b110011};
    tbl[6] = '{0, 2'b11, 3'd5, 4'h2, 3'b000, 12'h000, 3'b001, 4'h0, MEM_LAT,   6'b000000};
    tbl[7] = '{1, 2'b01, 3'd5, 4'h0, 3'b101, 12'h609, 3'b010, 4'h9, MEM_LAT+2, 6'b101101};

    do_reset(1'b1);

    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i]);
      predict(g, eack, lat, erd, ebus);
      run_check($sformatf("vec%0d", i), g, tbl[i].eack, tbl[i].elat, tbl[i].erd, tbl[i].ebus, 1'b0);
    end

    // Illegal op on the only requester: nothing happens.
    req = 3'b001; req_op = 6'b000000; req_addr = 9'd1;
    ok = 1;
    repeat (4) begin
      @(posedge clock); #1;
      if (busy !== 1'b0 || bus_out !== 6'd0 || ack !== 3'd0) ok = 0;
    end
    check("illegal_op_idle", 32'(ok), 32'd1);
    req = '0;

    // Reset asserted during MEM of a write-back aborts it.
    do_reset(1'b0);
    req = 3'b010; req_op = 6'b001100; req_addr = 9'(3'd2) << 3; req_data = 12'(4'h5) << 4;
    @(posedge clock); #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort_ack",   32'(ack),     32'd0);
    check("abort_busy",  32'(busy),    32'd0);
    check("abort_bus",   32'(bus_out), 32'd0);
    @(posedge clock); #1;
    check("abort_ack_hold", 32'(ack), 32'd0);
    reset_n = 1'b1;
    model_reset();
    req = 3'b011; req_op = 6'b001101; req_addr = {3'd0, 3'd2, 3'd2};
    predict(g, eack, lat, erd, ebus);
    run_check("post_abort", g, 3'b001, MEM_LAT + 2, 4'h0, 6'b101010, 1'b0);
    req = '0;

    // All three requesting continuously: round-robin 0,1,2,0.
    do_reset(1'b0);
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    req = 3'b111; req_op = 6'b010101; req_addr = {3'd4, 3'd2, 3'd1};
    for (int k = 0; k < 4; k++) begin
      predict(g, eack, lat, erd, ebus);
      run_check($sformatf("rr%0d", k), g, order[k], lat, erd, ebus, 1'b0);
      req[g] = 1'b1;
    end
    req = '0;

    // Random traffic against the transaction model.
    for (int it = 0; it < 150; it++) begin
      req        = 3'($urandom);
      req_op     = 6'($urandom);
      req_addr   = 9'($urandom);
      req_data   = 12'($urandom);
      snoop_wb   = 3'($urandom);
      snoop_data = 12'($urandom);
      predict(g, eack, lat, erd, ebus);
      if (g < 0) begin
        ok = 1;
        repeat (2) begin
          @(posedge clock); #1;
          if (busy !== 1'b0 || bus_out !== 6'd0) ok = 0;
        end
        check($sformatf("rnd%0d_nogrant", it), 32'(ok), 32'd1);
      end else begin
        run_check($sformatf("rnd%0d", it), g, eack, lat, erd, ebus, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_controller.md
BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports named clock and reset_n.
REQ-002 Parameter MEM_LAT, default 2, SHALL set memory access cycles; legal range 1..15.
REQ-003 clock  in  1  system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req  in  3  per-CPU bus request, bit i = CPU i; held high until ack[i] is seen.
REQ-006 req_op  in  6  2 bits per CPU {op[2i+1:2i]}: 01 read miss, 10 write miss, 11 write-back, 00 illegal (ignored).
REQ-007 req_addr  in  9  3-bit block address per CPU.
REQ-008 req_data  in  12  4-bit write-back data per CPU.
REQ-009 snoop_wb  in  3  CPU i holds the addressed block Modified and is flushing it.
REQ-010 snoop_data  in  12  4-bit flush data per CPU.
REQ-011 bus_out  out  6  broadcast message {valid, op[1:0], addr[2:0]} to all CPUs.
REQ-012 ack  out  3  one-hot, one-cycle completion pulse to the granted CPU.
REQ-013 rdata  out  4  block data for the granted CPU; valid only while ack is high.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Memory SHALL be an internal 8 x 4-bit array indexed by addr.
REQ-016 States SHALL be IDLE, BCAST, SNOOP, MEM, RESP.
REQ-017 IDLE: when any req bit is high with a legal op, grant one CPU by round-robin starting at (last_grant+1) mod 3, latch its op/addr/data, and leave IDLE; otherwise stay.
REQ-018 Read or write miss: IDLE -> BCAST -> SNOOP -> MEM -> RESP -> IDLE; write-back: IDLE -> MEM -> RESP -> IDLE.
REQ-019 BCAST: bus_out = {1, op, addr} for exactly one cycle; bus_out = 6'b000000 in every other state.
REQ-020 SNOOP (one cycle): the block SHALL sample snoop_wb at the end of the cycle, ignoring the requester's own bit; the lowest-index remaining responder supplies flush data.
REQ-021 On a snoop flush, the block SHALL write the flush data to mem[addr] and return it as rdata.
REQ-022 MEM SHALL last exactly MEM_LAT cycles, timed by a down-counter.
REQ-023 Read or write miss: at MEM exit the block SHALL set rdata = mem[addr], including any flush written in SNOOP.
REQ-024 Write-back: at MEM exit the block SHALL set mem[addr] = latched req_data; rdata = 0.
REQ-025 RESP (one cycle): the block SHALL drive ack = one-hot granted CPU and update last_grant.
REQ-026 Latency SHALL be: miss ack high MEM_LAT+2 edges after the accepting edge; write-back ack high MEM_LAT edges after it.
REQ-027 Requests arriving while busy SHALL wait, with no loss and no queueing beyond req.
REQ-028 The block SHALL ignore changes to req, op, addr, or data of the granted CPU after the grant.
REQ-029 Simultaneous requests SHALL be served one per transaction in round-robin order; a CPU that drops req before its grant is skipped.
REQ-030 A CPU deasserts req on the edge that samples ack; the block SHALL NOT re-grant it in the following IDLE cycle.

Reset
REQ-031 While reset_n is low: state = IDLE, bus_out = 0, ack = 0, rdata = 0, busy = 0, last_grant = 2 (so CPU0 has first priority), counter = 0, and all memory words = 0.
REQ-032 Reset mid-transaction SHALL abort it with no memory write and no ack, even when asserted in MEM or RESP.

Structure
REQ-033 Shared package bus_pkg SHALL hold: op codes (OP_NONE, OP_RMISS, OP_WMISS, OP_WB), state enum, N_CPU = 3, ADDR_W = 3, DATA_W = 4, BUS_W = 6.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector, last_grant; output: one-hot grant); the memory array and FSM stay in bus_controller.

Verification
REQ-035 After reset, CPU0 write-back op 11, addr 3, data 4'hA, MEM_LAT = 2 -> ack = 001 two edges after accept; then CPU1 read miss addr 3 -> bus_out = 6'b101011 for one cycle, rdata = 4'hA with ack = 010.
REQ-036 CPU2 read miss addr 5, snoop_wb = 001, snoop_data[3:0] = 4'h7 -> ack = 100, rdata = 4'h7; a later read of addr 5 returns 4'h7 from memory.
REQ-037 req = 111 held from reset -> grants in order CPU0, CPU1, CPU2, CPU0; each ack is one cycle; busy is continuous between transactions except one IDLE cycle.
REQ-038 Requester's own snoop_wb bit set (CPU1 miss, snoop_wb = 010) -> bit ignored, rdata from memory.
REQ-039 reset_n pulled low in the MEM state of a write-back to addr 2 -> no ack, mem[2] = 0, bus_out = 0, state IDLE, next grant to CPU0.
REQ-040 req_op = 00 on the only requesting CPU -> no grant, busy stays 0, bus_out stays 0.
